// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants and sequencer state encoding
package alu_pkg;

  localparam int ALU_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NEG_IN  = 3'd1,
    ST_ITER    = 3'd2,
    ST_NEG_OUT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/alu_signed_mult_seq_if.sv
// rtl/alu_signed_mult_seq_if.sv - operand/product handshake bundle for the signed multiplier
interface alu_signed_mult_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_prod;
  logic                 busy;

  // Requester side: supplies operands, consumes products.
  modport master (
    output flush, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod, busy
  );

  // Sequencer side.
  modport slave (
    input  flush, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod, busy
  );

endinterface

// File: rtl/alu_negate.sv
// rtl/alu_negate.sv - combinational two's-complement negation
module alu_negate #(
  parameter int W = 12
) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_b
);

  assign o_b = ~i_a + W'(1);

endmodule

// File: rtl/alu_signed_mult_seq.sv
// rtl/alu_signed_mult_seq.sv - sign/magnitude shift-add multiplier sequencer
module alu_signed_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_signed_mult_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_e             r_state;
  state_e             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_sign;
  logic [WIDTH-1:0]   r_a_mag;
  logic [WIDTH-1:0]   r_b_mag;
  logic [PW-1:0]      r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [PW-1:0]      r_prod;

  logic               w_accept;
  logic [PW-1:0]      w_neg_in;
  logic [PW-1:0]      w_neg_out;
  logic [WIDTH-1:0]   w_b_neg;
  logic [PW-1:0]      w_addend;

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out_prod  = r_prod;

  // flush beats a simultaneous operand offer
  assign w_accept = bus.in_valid && bus.in_ready && !bus.flush;

  // The wide negator is shared: operand a (zero-extended) in NEG_IN, accumulator in NEG_OUT.
  assign w_neg_in = (r_state == ST_NEG_OUT) ? r_acc : {{WIDTH{1'b0}}, r_a};

  alu_negate #(.W(PW)) u_neg_wide (
    .i_a (w_neg_in),
    .o_b (w_neg_out)
  );

  // Second narrow copy lets both magnitudes resolve in a single NEG_IN cycle.
  alu_negate #(.W(WIDTH)) u_neg_b (
    .i_a (r_b),
    .o_b (w_b_neg)
  );

  assign w_addend = r_b_mag[r_cnt] ? ({{WIDTH{1'b0}}, r_a_mag} << r_cnt) : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: linear walk through the phases, flush returns to IDLE from anywhere.
  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_accept) w_next = ST_NEG_IN;
        ST_NEG_IN:  w_next = ST_ITER;
        ST_ITER:    if (r_cnt == CNT_W'(WIDTH - 1)) w_next = ST_NEG_OUT;
        ST_NEG_OUT: w_next = ST_DONE;
        ST_DONE:    if (bus.out_ready) w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  // Datapath: capture operands, form magnitudes, accumulate partial products, fix sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_a_mag <= '0;
      r_b_mag <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a    <= bus.in_a;
            r_b    <= bus.in_b;
            r_sign <= bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
          end
        end
        ST_NEG_IN: begin
          // -2^(W-1) negates to itself, which read unsigned is the correct magnitude.
          r_a_mag <= r_a[WIDTH-1] ? w_neg_out[WIDTH-1:0] : r_a;
          r_b_mag <= r_b[WIDTH-1] ? w_b_neg : r_b;
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        ST_ITER: begin
          r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_NEG_OUT: begin
          r_prod <= r_sign ? w_neg_out : r_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_signed_mult_seq.sv
// tb/tb_alu_signed_mult_seq.sv - self-checking bench for the signed multiplier sequencer
module tb_alu_signed_mult_seq;

  localparam int W = 12;

  logic clk;
  logic rst_n;

  alu_signed_mult_seq_if #(.WIDTH(W)) bus ();

  alu_signed_mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb_q[$];

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                       input logic use_spec, input logic [2*W-1:0] spec_exp, input string name);
    logic [2*W-1:0] got;
    logic [2*W-1:0] exp;
    int lat;
    lat = 0;
    while (bus.in_ready !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    sb_q.push_back(model(a, b));
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 14) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, need 14", name, lat);
    end
    if (bus.out_valid !== 1'b1) begin
      void'(sb_q.pop_back());
      return;
    end
    got = bus.out_prod;
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_prod !== got || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s hold: valid=%b prod=%h ready=%b busy=%b, need valid=1 prod=%h ready=0 busy=1",
                 name, bus.out_valid, bus.out_prod, bus.in_ready, bus.busy, got);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp = sb_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s product: got %h, need %h", name, got, exp);
    end
    if (use_spec) begin
      checks++;
      if (got !== spec_exp) begin
        errors++;
        $display("FAIL %s spec product: got %h, need %h", name, got, spec_exp);
      end
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: valid=%b ready=%b, need valid=0 ready=1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_prod !== '0) begin
      errors++;
      $display("FAIL %s: ready=%b valid=%b busy=%b prod=%h, need 1 0 0 000000",
               name, bus.in_ready, bus.out_valid, bus.busy, bus.out_prod);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_op(12'd3, 12'd5, 0, 1'b1, 24'h00000F, "3x5");
    do_op(12'hFF9, 12'd6, 0, 1'b1, 24'hFFFFD6, "-7x6");
    do_op(12'hFFF, 12'hFFF, 0, 1'b1, 24'h000001, "-1x-1");
  endtask

  task automatic test_extremes();
    do_op(12'h800, 12'h800, 0, 1'b1, 24'h400000, "min_x_min");
    do_op(12'h7FF, 12'h800, 0, 1'b1, 24'hC00800, "max_x_min");
    do_op(12'h000, 12'hFFF, 0, 1'b1, 24'h000000, "zero_x_neg");
    do_op(12'h7FF, 12'h7FF, 0, 1'b1, 24'h3FF001, "max_x_max");
  endtask

  task automatic test_backpressure();
    do_op(12'hF00, 12'd9, 5, 1'b1, 24'hFFF700, "backpressure");
  endtask

  task automatic test_flush();
    int seen;
    bus.in_a     = 12'd5;
    bus.in_b     = 12'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    sb_q.push_back(model(12'd5, 12'd7));
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre busy: got %b, need 1", bus.busy);
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    void'(sb_q.pop_back());
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_iter: ready=%b valid=%b busy=%b, need 1 0 0", bus.in_ready, bus.out_valid, bus.busy);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_no_output: out_valid seen %0d cycles, need 0", seen);
    end
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_accept: busy=%b ready=%b, need 0 1", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    bus.in_a     = 12'd100;
    bus.in_b     = 12'hF9C;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    sb_q.push_back(model(12'd100, 12'hF9C));
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    check_reset_outputs("async_reset_mid_iter");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    do_op(12'd2, 12'hFFD, 0, 1'b1, 24'hFFFFFA, "after_reset_2x-3");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      do_op(a, b, i % 3, 1'b0, '0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
